// File: rtl/two_five_ser_enc_pkg.sv
// two_five_ser_enc_pkg: 2-of-5 code table, invalid code and encoder FSM states
package two_five_ser_enc_pkg;
    localparam logic [4:0] code_bad = 5'b11011;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
    function automatic logic [4:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 5'b01100;
            4'd1: enc = 5'b11000;
            4'd2: enc = 5'b10100;
            4'd3: enc = 5'b10010;
            4'd4: enc = 5'b01010;
            4'd5: enc = 5'b00110;
            4'd6: enc = 5'b10001;
            4'd7: enc = 5'b01001;
            4'd8: enc = 5'b00101;
            4'd9: enc = 5'b00011;
            default: enc = code_bad;
        endcase
    endfunction
endpackage

// File: rtl/two_five_digit_lut.sv
// two_five_digit_lut: one BCD digit to its 2-of-5 code, flagging non-BCD input
module two_five_digit_lut
    import two_five_ser_enc_pkg::*;
(
    input  logic [3:0] digit,
    output logic [4:0] code,
    output logic       invalid
);
    assign invalid = digit > 4'd9;
    assign code = enc(digit);
endmodule

// File: rtl/two_five_ser_enc.sv
// two_five_ser_enc: BCD word to 2-of-5 symbols plus optional mod-10 check,
// serialised MSB digit first, bit4 first, with valid/ready on both sides.
module two_five_ser_enc
    import two_five_ser_enc_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CHECK_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] din,
    output logic                ser_valid,
    input  logic                ser_ready,
    output logic                ser_bit,
    output logic                frame_start,
    output logic                frame_end,
    output logic                frame_err
);
    localparam int NSYM = DIGITS + CHECK_EN;
    localparam int SW = $clog2(9 * DIGITS + 1);
    localparam int IW = NSYM > 1 ? $clog2(NSYM) : 1;
    localparam logic [IW-1:0] last_sym = IW'(NSYM - 1);
    state_t state;
    logic [IW-1:0] sym_idx;
    logic [2:0] bit_idx;
    logic [4:0] code_q [NSYM];
    logic [4:0] code_d [NSYM];
    logic [3:0] dig [NSYM];
    logic [NSYM-1:0] inv;
    logic [SW-1:0] sum;
    logic [4:0] cur;
    logic err_q, last, beat, load;
    // Sum taken straight from din so the check digit never loops back into it
    always_comb begin
        sum = '0;
        for (int j = 0; j < DIGITS; j++)
            sum = sum + (din[4*j +: 4] > 4'd9 ? '0 : SW'(din[4*j +: 4]));
    end
    for (genvar i = 0; i < NSYM; i++) begin : g_sym
        if (i < DIGITS) begin : g_dat
            assign dig[i] = din[4*(DIGITS-1-i) +: 4];
        end else begin : g_chk
            assign dig[i] = 4'(sum % SW'(10));
        end
        two_five_digit_lut u_lut (.digit(dig[i]), .code(code_d[i]), .invalid(inv[i]));
    end
    assign last = (sym_idx == last_sym) && (bit_idx == 3'd4);
    assign ser_valid = state == SEND;
    assign beat = ser_valid && ser_ready;
    assign in_ready = (state == IDLE) || (beat && last);
    assign load = in_valid && in_ready;
    assign cur = code_q[sym_idx];
    assign ser_bit = ser_valid && cur[3'd4 - bit_idx];
    assign frame_start = ser_valid && sym_idx == '0 && bit_idx == 3'd0;
    assign frame_end = ser_valid && last;
    assign frame_err = frame_end && err_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            sym_idx <= '0;
            bit_idx <= '0;
            err_q   <= 1'b0;
            code_q  <= '{default: '0};
        end else if (load) begin
            state   <= SEND;
            sym_idx <= '0;
            bit_idx <= '0;
            err_q   <= |inv;
            code_q  <= code_d;
        end else if (beat) begin
            state   <= last ? IDLE : SEND;
            bit_idx <= bit_idx == 3'd4 ? 3'd0 : bit_idx + 3'd1;
            sym_idx <= last ? '0 : bit_idx == 3'd4 ? sym_idx + 1'b1 : sym_idx;
        end
endmodule

// File: tb/tb_two_five_ser_enc.sv
// tb_two_five_ser_enc: directed frames with hand-computed 2-of-5 bit streams,
// covering errors, stalls, back-to-back words, mid-frame reset and a 1-digit build.
module tb_two_five_ser_enc;
    logic clk = 0, rst = 1, in_valid = 0, ser_ready = 1;
    logic [15:0] din = '0;
    logic in_ready, ser_valid, ser_bit, frame_start, frame_end, frame_err;
    logic in_valid2 = 0, ser_ready2 = 1;
    logic [3:0] din2 = '0;
    logic in_ready2, ser_valid2, ser_bit2, fs2, fe2, ferr2;
    int checks = 0, errors = 0;
    logic [79:0] bits, fsm, fem, ferm, irm;
    int cyc;
    logic held;

    always #5 clk = ~clk;

    two_five_ser_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit),
        .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err)
    );

    two_five_ser_enc #(.DIGITS(1), .CHECK_EN(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .din(din2),
        .ser_valid(ser_valid2), .ser_ready(ser_ready2), .ser_bit(ser_bit2),
        .frame_start(fs2), .frame_end(fe2), .frame_err(ferr2)
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [15:0] w);
        din = w;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    // Collect n accepted beats, optionally holding ser_ready low for stall_n cycles before beat stall_at
    task automatic capture(input int n, input int stall_at, input int stall_n);
        int got = 0, st = 0;
        logic sb = 0;
        bits = '0; fsm = '0; fem = '0; ferm = '0; irm = '0; cyc = 0; held = 1;
        while (got < n && cyc < 200) begin
            ser_ready = !(got == stall_at && st < stall_n);
            #1;
            if (!ser_ready) begin
                if (st == 0) sb = ser_bit;
                else if (ser_bit !== sb) held = 0;
                st++;
            end else if (ser_valid) begin
                if (st > 0 && got == stall_at && ser_bit !== sb) held = 0;
                bits = {bits[78:0], ser_bit};
                fsm[got] = frame_start;
                fem[got] = frame_end;
                ferm[got] = frame_err;
                irm[got] = in_ready;
                got++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        ser_ready = 1;
        chk("beats", 80'(got), 80'(n));
    endtask

    initial begin
        logic [79:0] b2, s2, e2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ser_bit", ser_bit, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_in_ready2", in_ready2, 1);
        rst = 0;
        @(posedge clk); #1;

        accept(16'h1234);
        capture(25, -1, 0);
        chk("t1_bits", bits, 25'b11000_10100_10010_01010_01100);
        chk("t1_fs", fsm, 80'd1);
        chk("t1_fe", fem, 80'd1 << 24);
        chk("t1_ferr", ferm, 0);
        chk("t1_idle", ser_valid, 0);

        accept(16'h12A4);
        capture(25, -1, 0);
        chk("t2_bits", bits, 25'b11000_10100_11011_01010_01001);
        chk("t2_fe", fem, 80'd1 << 24);
        chk("t2_ferr", ferm, 80'd1 << 24);

        accept(16'h9876);
        capture(25, 6, 3);
        chk("t3_bits", bits, 25'b00011_00101_01001_10001_01100);
        chk("t3_cycles", 80'(cyc), 80'd28);
        chk("t3_held", held, 1);

        din = 16'h0000;
        in_valid = 1;
        @(posedge clk); #1;
        din = 16'h9999;
        capture(25, -1, 0);
        chk("t4_bits_a", bits, 25'b01100_01100_01100_01100_01100);
        chk("t4_in_ready", irm, 80'd1 << 24);
        chk("t4_b2b_start", frame_start, 1);
        in_valid = 0;
        capture(25, -1, 0);
        chk("t4_bits_b", bits, 25'b00011_00011_00011_00011_10001);
        chk("t4_fe_b", fem, 80'd1 << 24);

        accept(16'h1234);
        capture(11, -1, 0);
        rst = 1;
        @(posedge clk); #1;
        chk("t5_rst_valid", ser_valid, 0);
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_bit", ser_bit, 0);
        rst = 0;
        @(posedge clk); #1;
        accept(16'h5555);
        capture(25, -1, 0);
        chk("t5_bits", bits, 25'b00110_00110_00110_00110_01100);
        chk("t5_fs", fsm, 80'd1);

        din2 = 4'h7;
        in_valid2 = 1;
        @(posedge clk); #1;
        in_valid2 = 0;
        b2 = '0; s2 = '0; e2 = '0;
        for (int k = 0; k < 5; k++) begin
            b2 = {b2[78:0], ser_bit2};
            s2[k] = fs2;
            e2[k] = fe2;
            @(posedge clk); #1;
        end
        chk("t6_bits", b2, 5'b01001);
        chk("t6_fs", s2, 80'd1);
        chk("t6_fe", e2, 80'd1 << 4);
        chk("t6_idle", ser_valid2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
